// File: rtl/osd_hex_write_scheduler_pkg.sv
// Shared types and helpers for the OSD text-buffer write path.
package osd_pkg;

  localparam int OSD_ADDR_W = 7;
  localparam logic [7:0] OSD_SPACE = 8'h20;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WR_HI = 2'd1,
    WR_LO = 2'd2,
    CLEAR = 2'd3
  } osd_state_t;

  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    if (n < 4'd10) return 8'h30 + {4'd0, n};
    else           return 8'h41 + {4'd0, n - 4'd10};
  endfunction

endpackage

// File: rtl/osd_hex_write_scheduler_if.sv
// Single write port into the OSD text buffer.
interface osd_hex_write_scheduler_if #(
  parameter int ADDR_W = 7
);
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;
  logic              wr_en;

  modport master (output wr_addr, output wr_data, output wr_en);
  modport slave  (input  wr_addr, input  wr_data, input  wr_en);
endinterface

// File: rtl/osd_rr_arbiter.sv
// Combinational round-robin pick: searches from last+1 upward (mod N).
module osd_rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  pend,
  input  logic [IW-1:0] last,
  output logic [IW-1:0] grant_idx,
  output logic          grant_valid
);

  int idx;

  always_comb begin
    grant_idx   = '0;
    grant_valid = 1'b0;
    idx         = 0;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(last) + k) % N;
      if (!grant_valid && pend[idx]) begin
        grant_valid = 1'b1;
        grant_idx   = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/osd_hex_write_scheduler.sv
// Serialises per-channel hex display requests and screen clears onto the
// single text_buffer write port.
//
// state | meaning
// IDLE  | no write; arbitrate clear first, then round-robin hex jobs
// WR_HI | write high-nibble ASCII at base
// WR_LO | write low-nibble ASCII at base+1
// CLEAR | write space at cnt, sweeping every cell
module osd_hex_write_scheduler
  import osd_pkg::*;
#(
  parameter int N           = 4,
  parameter int COLS        = 16,
  parameter int ADDR_W      = OSD_ADDR_W,
  parameter bit VBLANK_ONLY = 1'b0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       vblank,
  input  logic                       clear_req,
  input  logic [N-1:0]               req,
  input  logic [4*N-1:0]             linea,
  input  logic [5*N-1:0]             columna,
  input  logic [8*N-1:0]             value,
  osd_hex_write_scheduler_if.master  wr,
  output logic                       busy
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  osd_state_t        state_q, state_d;
  logic [N-1:0]      pend_q;
  logic              clr_pend_q;
  logic [IW-1:0]     last_q;
  logic [ADDR_W-1:0] cnt_q;
  logic [ADDR_W-1:0] base_q;
  logic [7:0]        work_val_q;

  logic [3:0]        lin_q [N];
  logic [4:0]        col_q [N];
  logic [7:0]        val_q [N];

  logic [IW-1:0]     grant_idx;
  logic              grant_valid;
  logic              start_ok;
  logic              do_clr;
  logic              do_job;
  logic [15:0]       base_full;

  logic              en_c;
  logic [ADDR_W-1:0] addr_c;
  logic [7:0]        data_c;

  osd_rr_arbiter #(.N(N), .IW(IW)) u_arb (
    .pend        (pend_q),
    .last        (last_q),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  // Columns past COLS deliberately spill into following lines.
  assign base_full = 16'(lin_q[grant_idx]) * 16'(COLS) + 16'(col_q[grant_idx]);
  assign start_ok  = !VBLANK_ONLY || vblank;

  always_comb begin
    state_d = state_q;
    do_clr  = 1'b0;
    do_job  = 1'b0;
    en_c    = 1'b0;
    addr_c  = '0;
    data_c  = '0;
    case (state_q)
      IDLE: begin
        if (start_ok) begin
          if (clr_pend_q) begin
            do_clr  = 1'b1;
            state_d = CLEAR;
          end else if (grant_valid) begin
            do_job  = 1'b1;
            state_d = WR_HI;
          end
        end
      end
      WR_HI: begin
        en_c    = 1'b1;
        addr_c  = base_q;
        data_c  = hex_ascii(work_val_q[7:4]);
        state_d = WR_LO;
      end
      WR_LO: begin
        en_c    = 1'b1;
        addr_c  = base_q + 1'b1;
        data_c  = hex_ascii(work_val_q[3:0]);
        state_d = IDLE;
      end
      CLEAR: begin
        en_c   = 1'b1;
        addr_c = cnt_q;
        data_c = OSD_SPACE;
        if (cnt_q == '1) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      pend_q     <= '0;
      clr_pend_q <= 1'b0;
      last_q     <= IW'(N - 1);
      cnt_q      <= '0;
      base_q     <= '0;
      work_val_q <= '0;
      for (int i = 0; i < N; i++) begin
        lin_q[i] <= '0;
        col_q[i] <= '0;
        val_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;

      if (do_clr)                cnt_q <= '0;
      else if (state_q == CLEAR) cnt_q <= cnt_q + 1'b1;

      if (clear_req)   clr_pend_q <= 1'b1;
      else if (do_clr) clr_pend_q <= 1'b0;

      if (do_job) begin
        last_q     <= grant_idx;
        base_q     <= base_full[ADDR_W-1:0];
        work_val_q <= val_q[grant_idx];
      end

      // A new request on the grant edge keeps the channel pending.
      for (int i = 0; i < N; i++) begin
        if (req[i]) begin
          pend_q[i] <= 1'b1;
          lin_q[i]  <= linea[4*i +: 4];
          col_q[i]  <= columna[5*i +: 5];
          val_q[i]  <= value[8*i +: 8];
        end else if (do_job && grant_idx == IW'(i)) begin
          pend_q[i] <= 1'b0;
        end
      end
    end
  end

  assign wr.wr_en   = en_c;
  assign wr.wr_addr = addr_c;
  assign wr.wr_data = data_c;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_osd_hex_write_scheduler.sv
// Directed scoreboard bench for osd_hex_write_scheduler (ungated and vblank-gated instances).
module tb_osd_hex_write_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic        vblank_a, vblank_b;
  logic        clear_req_a, clear_req_b;
  logic [3:0]  req_a, req_b;
  logic [15:0] lin_a, lin_b;
  logic [19:0] col_a, col_b;
  logic [31:0] val_a, val_b;
  logic        busy_a, busy_b;

  int total = 0;
  int bad   = 0;

  logic [14:0] qa [$];
  logic [14:0] qb [$];

  always #5 clk = ~clk;

  osd_hex_write_scheduler_if #(.ADDR_W(7)) wa ();
  osd_hex_write_scheduler_if #(.ADDR_W(7)) wb ();

  osd_hex_write_scheduler #(.N(4), .COLS(16), .ADDR_W(7), .VBLANK_ONLY(1'b0)) dut_a (
    .clk(clk), .reset(reset), .vblank(vblank_a), .clear_req(clear_req_a),
    .req(req_a), .linea(lin_a), .columna(col_a), .value(val_a),
    .wr(wa), .busy(busy_a)
  );

  osd_hex_write_scheduler #(.N(4), .COLS(16), .ADDR_W(7), .VBLANK_ONLY(1'b1)) dut_b (
    .clk(clk), .reset(reset), .vblank(vblank_b), .clear_req(clear_req_b),
    .req(req_b), .linea(lin_b), .columna(col_b), .value(val_b),
    .wr(wb), .busy(busy_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] hx(input logic [3:0] n);
    return (n < 4'd10) ? 8'h30 + 8'(n) : 8'h37 + 8'(n);
  endfunction

  task automatic push_job(input bit to_b, input int l, input int c, input logic [7:0] v);
    logic [6:0] base;
    base = 7'((l * 16 + c) % 128);
    if (to_b) begin
      qb.push_back({base, hx(v[7:4])});
      qb.push_back({7'(base + 7'd1), hx(v[3:0])});
    end else begin
      qa.push_back({base, hx(v[7:4])});
      qa.push_back({7'(base + 7'd1), hx(v[3:0])});
    end
  endtask

  task automatic set_a(input int ch, input logic [3:0] l, input logic [4:0] c, input logic [7:0] v);
    lin_a[4*ch +: 4] = l;
    col_a[5*ch +: 5] = c;
    val_a[8*ch +: 8] = v;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while ((qa.size() != 0 || qb.size() != 0) && n < 600) begin
      tick();
      n++;
    end
    repeat (4) tick();
    chk(tag, 32'(qa.size() + qb.size()), 32'd0);
  endtask

  // Scoreboard: every write must match the oldest outstanding expectation.
  always @(negedge clk) begin
    logic [14:0] e;
    if (wa.wr_en === 1'b1) begin
      if (qa.size() == 0) chk("a_spurious_write", 32'(wa.wr_en), 32'd0);
      else begin
        e = qa.pop_front();
        chk("a_addr", 32'(wa.wr_addr), 32'(e[14:8]));
        chk("a_data", 32'(wa.wr_data), 32'(e[7:0]));
      end
    end
    if (wb.wr_en === 1'b1) begin
      if (qb.size() == 0) chk("b_spurious_write", 32'(wb.wr_en), 32'd0);
      else begin
        e = qb.pop_front();
        chk("b_addr", 32'(wb.wr_addr), 32'(e[14:8]));
        chk("b_data", 32'(wb.wr_data), 32'(e[7:0]));
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int busy_cnt;
    reset = 1'b1;
    vblank_a = 1'b0; vblank_b = 1'b0;
    clear_req_a = 1'b0; clear_req_b = 1'b0;
    req_a = '0; req_b = '0;
    lin_a = '0; col_a = '0; val_a = '0;
    lin_b = '0; col_b = '0; val_b = '0;
    repeat (3) tick();
    reset = 1'b0;

    // Reset state
    chk("rst_wr_en",   32'(wa.wr_en),   32'd0);
    chk("rst_busy",    32'(busy_a),     32'd0);
    chk("rst_wr_addr", 32'(wa.wr_addr), 32'd0);
    chk("rst_wr_data", 32'(wa.wr_data), 32'd0);
    chk("rst_busy_b",  32'(busy_b),     32'd0);

    // Contention: all four at once, fresh from reset -> ch0..ch3
    for (int i = 0; i < 4; i++) set_a(i, 4'(i), 5'd0, 8'(i * 8'h11));
    set_a(2, 4'd2, 5'd0, 8'hAA);
    set_a(3, 4'd3, 5'd0, 8'hFF);
    push_job(0, 0, 0, 8'h00);
    push_job(0, 1, 0, 8'h11);
    push_job(0, 2, 0, 8'hAA);
    push_job(0, 3, 0, 8'hFF);
    req_a = 4'b1111;
    tick(); req_a = '0;
    repeat (11) tick();
    chk("cont_last_en",   32'(wa.wr_en),   32'd1);
    chk("cont_last_addr", 32'(wa.wr_addr), 32'd49);
    tick();
    chk("cont_done_en", 32'(wa.wr_en), 32'd0);
    drain("cont_drain");

    // Single request, latency check
    set_a(0, 4'd1, 5'd8, 8'h3C);
    push_job(0, 1, 8, 8'h3C);
    req_a = 4'b0001;
    tick(); req_a = '0;
    chk("single_c1_en", 32'(wa.wr_en), 32'd0);
    tick();
    chk("single_hi_en",   32'(wa.wr_en),   32'd1);
    chk("single_hi_addr", 32'(wa.wr_addr), 32'd24);
    chk("single_hi_data", 32'(wa.wr_data), 32'h33);
    tick();
    chk("single_lo_addr", 32'(wa.wr_addr), 32'd25);
    chk("single_lo_data", 32'(wa.wr_data), 32'h43);
    tick();
    chk("single_end_en",   32'(wa.wr_en), 32'd0);
    chk("single_end_busy", 32'(busy_a),   32'd0);
    drain("single_drain");

    // Coalescing: ch2 updated twice while ch0 holds the port
    set_a(0, 4'd0, 5'd0, 8'h55);
    push_job(0, 0, 0, 8'h55);
    req_a = 4'b0001;
    tick(); req_a = '0;
    tick();
    set_a(2, 4'd2, 5'd4, 8'h12); req_a = 4'b0100;
    tick();
    set_a(2, 4'd2, 5'd4, 8'h34); req_a = 4'b0100;
    tick(); req_a = '0;
    push_job(0, 2, 4, 8'h34);
    drain("coal_drain");

    // Clear beats a simultaneous hex request
    set_a(1, 4'd3, 5'd2, 8'h9E);
    for (int i = 0; i < 128; i++) qa.push_back({7'(i), 8'h20});
    push_job(0, 3, 2, 8'h9E);
    clear_req_a = 1'b1; req_a = 4'b0010;
    tick(); clear_req_a = 1'b0; req_a = '0;
    busy_cnt = 0;
    for (int i = 0; i < 128; i++) begin
      tick();
      if (busy_a === 1'b1) busy_cnt++;
    end
    chk("clear_busy_cycles", 32'(busy_cnt), 32'd128);
    drain("clear_drain");

    // Address wrap: base 127, low char lands at 0
    set_a(3, 4'd7, 5'd15, 8'hB7);
    push_job(0, 7, 15, 8'hB7);
    req_a = 4'b1000;
    tick(); req_a = '0;
    drain("wrap_drain");

    // Vblank gating on instance B
    lin_b[3:0] = 4'd0; col_b[4:0] = 5'd3; val_b[7:0] = 8'h4D;
    push_job(1, 0, 3, 8'h4D);
    req_b = 4'b0001;
    tick(); req_b = '0;
    repeat (5) tick();
    chk("gate_busy_low", 32'(busy_b),   32'd0);
    chk("gate_en_low",   32'(wb.wr_en), 32'd0);
    vblank_b = 1'b1;
    tick();
    chk("gate_hi_en",   32'(wb.wr_en),   32'd1);
    chk("gate_hi_addr", 32'(wb.wr_addr), 32'd3);
    vblank_b = 1'b0;
    tick();
    chk("gate_lo_en",   32'(wb.wr_en),   32'd1);
    chk("gate_lo_addr", 32'(wb.wr_addr), 32'd4);
    drain("gate_drain");

    // Reset during WR_HI abandons the job; ch0 granted first afterwards
    set_a(2, 4'd0, 5'd9, 8'h6A);
    qa.push_back({7'd9, 8'h36});
    req_a = 4'b0100;
    tick(); req_a = '0;
    tick();
    chk("rstmid_hi_en", 32'(wa.wr_en), 32'd1);
    reset = 1'b1;
    tick();
    chk("rstmid_en",   32'(wa.wr_en), 32'd0);
    chk("rstmid_busy", 32'(busy_a),   32'd0);
    reset = 1'b0;
    set_a(0, 4'd1, 5'd1, 8'h01);
    set_a(3, 4'd2, 5'd2, 8'h02);
    push_job(0, 1, 1, 8'h01);
    push_job(0, 2, 2, 8'h02);
    req_a = 4'b1001;
    tick(); req_a = '0;
    drain("rstmid_drain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/osd_hex_write_scheduler.md
# osd_hex_write_scheduler

Write-port scheduler for the OSD text buffer. It accepts hex-value display requests from N independent requesters (line, column, 8-bit value) and a whole-screen clear request. It serialises them into single-cycle writes of two uppercase ASCII hex characters on the one `text_buffer` write port. It sits between the debug-value sources and `text_buffer`, replacing direct per-writer connections, and has no effect on the read/render path.

## Interface
Parameters:
- `N`, 4: number of requesters.
- `COLS`, 16: characters per text line, used in address computation.
- `ADDR_W`, 7: text buffer address width (2^ADDR_W cells).
- `VBLANK_ONLY`, 0: if 1, new jobs start only while `vblank`=1.

Ports (name, direction, width, meaning):
- `clk` in 1: system clock; the only clock.
- `reset` in 1: synchronous, active-high.
- `vblank` in 1: vertical blank level, used only when `VBLANK_ONLY`=1.
- `clear_req` in 1: one-cycle pulse requesting that every cell be filled with space.
- `req` in N: per-requester write pulse.
- `linea` in 4*N: line of requester i at bits [4i+3:4i].
- `columna` in 5*N: column of requester i.
- `value` in 8*N: byte to display for requester i.
- `wr_addr` out ADDR_W: text buffer write address.
- `wr_data` out 8: text buffer write data.
- `wr_en` out 1: text buffer write enable.
- `busy` out 1: high whenever state ≠ IDLE.

## Operation
- Per-channel capture: `req[i]`=1 at an edge sets `pend[i]` and latches that channel's linea, columna and value. A new req while pending overwrites the latched data (coalescing; the last value wins). No request is ever dropped.
- `clear_req` sets `clr_pend`.
- FSM states are IDLE, WR_HI, WR_LO and CLEAR.
- IDLE transitions:
  - If the start condition is met (`VBLANK_ONLY`=0, or `vblank`=1), the priority is as follows.
  - `clr_pend` wins. Clear `clr_pend`, set cnt=0, go to CLEAR.
  - Otherwise, if any `pend` is set, grant round-robin starting at `last+1` (mod N). Clear `pend[g]`, set `last`=g, and copy the latched data into work registers. Go to WR_HI.
- WR_HI: `wr_en`=1, `wr_addr`=base, `wr_data`=hex(value[7:4]). Go to WR_LO.
- WR_LO: `wr_en`=1, `wr_addr`=(base+1) mod 2^ADDR_W, `wr_data`=hex(value[3:0]). Go to IDLE.
- CLEAR: `wr_en`=1, `wr_addr`=cnt, `wr_data`=8'h20. cnt increments each cycle. After cnt=2^ADDR_W−1, go to IDLE.
- Address rule: base = (linea*COLS + columna) mod 2^ADDR_W. Columns ≥ COLS spill into following lines. Address 127 wraps its low character to 0.
- hex(n): n<10 gives 8'h30+n; otherwise 8'h41+(n−10) (uppercase).
- An in-flight job (WR_HI/WR_LO pair, or a full CLEAR) always completes; `vblank` falling mid-job has no effect.
- A `req` on the edge where that channel is granted: the work registers take the old data, and `pend` stays set with the new data, because set wins over clear.
- Requests and clears arriving during any job are queued and preserved.
- A `clear_req` during CLEAR sets `clr_pend`, which causes one more full clear afterwards.
- Reset values: state=IDLE, `pend`=0, `clr_pend`=0, `last`=N−1 (so channel 0 is granted first), cnt=0, `wr_en`=0, `wr_addr`=0, `wr_data`=0, `busy`=0.
- Reset mid-job abandons the job. Its partial writes are not undone.

## Timing
- Outputs are decoded from registered state and work registers. No combinational path runs from any input to any output.
- With `req[i]` high in cycle c and the scheduler idle and ungated:
  - grant at the end of c+1;
  - `wr_en` high in cycles c+2 (high nibble) and c+3 (low nibble).
- Back-to-back jobs: IDLE costs one cycle, so each hex job occupies 3 cycles. Sustained throughput is one job per 3 cycles.
- CLEAR is `wr_en` high for 2^ADDR_W consecutive cycles. A clear therefore costs 1 + 2^ADDR_W cycles after the pulse.
- `busy` is high exactly in the non-IDLE cycles.

## Structure
- Package `osd_pkg` holds:
  - `OSD_ADDR_W`;
  - `OSD_SPACE` = 8'h20;
  - the state enum (IDLE, WR_HI, WR_LO, CLEAR);
  - function `hex_ascii(input [3:0])`.
- Sub-module `osd_rr_arbiter` is purely combinational. Inputs are `pend[N-1:0]` and `last`; outputs are `grant_idx` and `grant_valid`. It is reusable for other shared OSD resources.

## Test plan
- Single request: ch0, linea=1, columna=8, value=8'h3C, idle → writes (24, 8'h33) in c+2, then (25, 8'h43) in c+3, then `wr_en`=0.
- Contention: `req`=4'b1111 in one cycle, values 8'h00/8'h11/8'hAA/8'hFF → grant order ch0, ch1, ch2, ch3. The last pair is (8'h46, 8'h46). Total 12 cycles.
- Coalescing: ch2 req value 8'h12, then 8'h34 while ch0 holds the port → ch2 writes "34" only, once.
- Clear priority: `clear_req` plus ch1 req in the same cycle → 128 writes of 8'h20 to addresses 0..127, then the ch1 pair. `busy` stays high throughout.
- Gating: `VBLANK_ONLY`=1, req with `vblank`=0 → no `wr_en`. Raise `vblank` → the pair is written. Drop `vblank` between HI and LO → the LO write still occurs.
- Wrap and reset: linea=7, columna=15 with COLS=16 (base 127) → writes to 127 then 0. Assert `reset` during WR_HI → next cycle `wr_en`=0, `busy`=0, and the first grant afterwards goes to ch0.
